scan_sequencer_nbit: RTL and testbench

- Upstream index generator for the N-bit enable-gated one-hot decoder.
- Drives `a` (N-bit index) and `enable` to step through a programmable inclusive index range.
- Holds each index for a programmable dwell time, in one-shot or continuous mode.
- Typical use: row/column scanning (LED matrix, keypad, chip-select sweep).

---
 rtl/scan_seq_pkg.sv | 14 +
 rtl/scan_dwell_timer.sv | 25 ++
 rtl/scan_sequencer_nbit.sv | 157 +++++++++++++++
 tb/tb_scan_sequencer_nbit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/scan_seq_pkg.sv
// Shared types and constants for the scan sequencer: FSM state encoding and reset index.
package scan_seq_pkg;

  localparam int STATE_W   = 2;
  localparam int RESET_IDX = 0;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/scan_dwell_timer.sv
// Per-index dwell counter: counts while run is high, expire flags count==limit.
module scan_dwell_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               run,
  input  logic [DWELL_W-1:0] limit,
  output logic               expire
);

  logic [DWELL_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_reg <= '0;
    end else if (run) begin
      count_reg <= count_reg + DWELL_W'(1);
    end
  end

  assign expire = (count_reg == limit);

endmodule

// File: rtl/scan_sequencer_nbit.sv
// Index generator stepping a downstream one-hot decoder through an inclusive range.
// Optional macro SCAN_SEQUENCER_GAP_EN inserts an enable-low GAP cycle before every index change.
module scan_sequencer_nbit
  import scan_seq_pkg::*;
#(
  parameter int N       = 3,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode_cont,
  input  logic [N-1:0]       first_idx,
  input  logic [N-1:0]       last_idx,
  input  logic [DWELL_W-1:0] dwell,
  output logic [N-1:0]       a,
  output logic               enable,
  output logic               busy,
  output logic               done,
  output logic               wrap
);

  state_t             state_reg, state_next;
  logic [N-1:0]       a_reg, a_next;
  logic               enable_reg, enable_next;
  logic               done_reg, done_next;
  logic               wrap_reg, wrap_next;
  logic [N-1:0]       first_reg, first_next;
  logic [N-1:0]       last_reg, last_next;
  logic [DWELL_W-1:0] dwell_reg, dwell_next;
  logic               mode_reg, mode_next;

  logic timer_clear;
  logic timer_run;
  logic timer_expire;

  // Counter only advances in SCAN, so it always enters SCAN at zero.
  assign timer_run   = (state_reg == ST_SCAN);
  assign timer_clear = (state_reg != ST_SCAN) || timer_expire;

  scan_dwell_timer #(
    .DWELL_W(DWELL_W)
  ) u_dwell_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (timer_clear),
    .run   (timer_run),
    .limit (dwell_reg),
    .expire(timer_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      a_reg      <= N'(RESET_IDX);
      enable_reg <= 1'b0;
      done_reg   <= 1'b0;
      wrap_reg   <= 1'b0;
      first_reg  <= '0;
      last_reg   <= '0;
      dwell_reg  <= '0;
      mode_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      a_reg      <= a_next;
      enable_reg <= enable_next;
      done_reg   <= done_next;
      wrap_reg   <= wrap_next;
      first_reg  <= first_next;
      last_reg   <= last_next;
      dwell_reg  <= dwell_next;
      mode_reg   <= mode_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    enable_next = enable_reg;
    done_next   = 1'b0;
    wrap_next   = 1'b0;
    first_next  = first_reg;
    last_next   = last_reg;
    dwell_next  = dwell_reg;
    mode_next   = mode_reg;

    case (state_reg)
      ST_IDLE: begin
        enable_next = 1'b0;
        if (start && !stop) begin
          first_next  = first_idx;
          last_next   = last_idx;
          dwell_next  = dwell;
          mode_next   = mode_cont;
          state_next  = ST_SCAN;
          a_next      = first_idx;
          enable_next = 1'b1;
        end
      end

      ST_SCAN: begin
        // stop outranks any end-of-range event, so no pulse escapes.
        if (stop) begin
          state_next  = ST_IDLE;
          enable_next = 1'b0;
        end else if (timer_expire) begin
          if (a_reg != last_reg) begin
            a_next = a_reg + N'(1);
`ifdef SCAN_SEQUENCER_GAP_EN
            state_next  = ST_GAP;
            enable_next = 1'b0;
`endif
          end else if (mode_reg) begin
            a_next    = first_reg;
            wrap_next = 1'b1;
`ifdef SCAN_SEQUENCER_GAP_EN
            state_next  = ST_GAP;
            enable_next = 1'b0;
`endif
          end else begin
            state_next  = ST_DONE;
            enable_next = 1'b0;
            done_next   = 1'b1;
          end
        end
      end

      ST_GAP: begin
        if (stop) begin
          state_next  = ST_IDLE;
          enable_next = 1'b0;
        end else begin
          state_next  = ST_SCAN;
          enable_next = 1'b1;
        end
      end

      ST_DONE: begin
        state_next  = ST_IDLE;
        enable_next = 1'b0;
      end

      default: begin
        state_next  = ST_IDLE;
        enable_next = 1'b0;
      end
    endcase
  end

  assign a      = a_reg;
  assign enable = enable_reg;
  assign busy   = (state_reg == ST_SCAN) || (state_reg == ST_GAP);
  assign done   = done_reg;
  assign wrap   = wrap_reg;

endmodule

// File: tb/tb_scan_sequencer_nbit.sv
// Directed vector bench for scan_sequencer_nbit; the table switches with SCAN_SEQUENCER_GAP_EN.
module tb_scan_sequencer_nbit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic       mode_cont;
  logic [2:0] first_idx;
  logic [2:0] last_idx;
  logic [7:0] dwell;
  logic [2:0] a;
  logic       enable;
  logic       busy;
  logic       done;
  logic       wrap;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scan_sequencer_nbit #(
    .N      (3),
    .DWELL_W(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .mode_cont(mode_cont),
    .first_idx(first_idx),
    .last_idx (last_idx),
    .dwell    (dwell),
    .a        (a),
    .enable   (enable),
    .busy     (busy),
    .done     (done),
    .wrap     (wrap)
  );

  typedef struct packed {
    logic       rst;
    logic       start;
    logic       stop;
    logic       mode;
    logic [2:0] first;
    logic [2:0] last;
    logic [7:0] dwell;
    logic [2:0] ea;
    logic       een;
    logic       ebusy;
    logic       edone;
    logic       ewrap;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic r, input logic st, input logic sp, input logic m,
                         input logic [2:0] f, input logic [2:0] l, input logic [7:0] d,
                         input logic [2:0] ea, input logic een, input logic eb,
                         input logic ed, input logic ew);
    vec_t v;
    v = '{rst: r, start: st, stop: sp, mode: m, first: f, last: l, dwell: d,
          ea: ea, een: een, ebusy: eb, edone: ed, ewrap: ew};
    vecs.push_back(v);
  endtask

  // Idle cycle with junk config on the inputs; it must be ignored while scanning.
  task automatic add_idle(input logic [2:0] ea, input logic een, input logic eb,
                          input logic ed, input logic ew);
    add_vec(1'b0, 1'b0, 1'b0, 1'b1, 3'd7, 3'd0, 8'd0, ea, een, eb, ed, ew);
  endtask

  task automatic drive(input vec_t v);
    rst       = v.rst;
    start     = v.start;
    stop      = v.stop;
    mode_cont = v.mode;
    first_idx = v.first;
    last_idx  = v.last;
    dwell     = v.dwell;
  endtask

  initial begin
    int en_cycles;
    int cyc;
    bit seen_done;
    logic [6:0] act;
    logic [6:0] exp;

    rst = 1'b1; start = 1'b0; stop = 1'b0; mode_cont = 1'b0;
    first_idx = '0; last_idx = '0; dwell = '0;

    // Two reset cycles.
    add_vec(1, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0);
    add_vec(1, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0);
`ifndef SCAN_SEQUENCER_GAP_EN
    // One-shot 2..4, dwell 1.
    add_vec(0, 1, 0, 0, 3'd2, 3'd4, 8'd1, 3'd2, 1, 1, 0, 0);
    add_idle(3'd2, 1, 1, 0, 0);
    add_idle(3'd3, 1, 1, 0, 0);
    add_idle(3'd3, 1, 1, 0, 0);
    add_idle(3'd4, 1, 1, 0, 0);
    add_idle(3'd4, 1, 1, 0, 0);
    add_idle(3'd4, 0, 0, 1, 0);
    add_idle(3'd4, 0, 0, 0, 0);
    // Continuous 6..1 across the index wrap, dwell 0.
    add_vec(0, 1, 0, 1, 3'd6, 3'd1, 8'd0, 3'd6, 1, 1, 0, 0);
    add_idle(3'd7, 1, 1, 0, 0);
    add_idle(3'd0, 1, 1, 0, 0);
    add_idle(3'd1, 1, 1, 0, 0);
    add_idle(3'd6, 1, 1, 0, 1);
    add_idle(3'd7, 1, 1, 0, 0);
    add_idle(3'd0, 1, 1, 0, 0);
    add_idle(3'd1, 1, 1, 0, 0);
    add_idle(3'd6, 1, 1, 0, 1);
    add_vec(0, 0, 1, 0, 0, 0, 0, 3'd6, 0, 0, 0, 0);
    // Single index 5, dwell 3, one-shot.
    add_vec(0, 1, 0, 0, 3'd5, 3'd5, 8'd3, 3'd5, 1, 1, 0, 0);
    add_idle(3'd5, 1, 1, 0, 0);
    add_idle(3'd5, 1, 1, 0, 0);
    add_idle(3'd5, 1, 1, 0, 0);
    add_idle(3'd5, 0, 0, 1, 0);
    add_idle(3'd5, 0, 0, 0, 0);
    // dwell 7 scan: restart ignored while busy, stop aborts.
    add_vec(0, 1, 0, 0, 3'd1, 3'd3, 8'd7, 3'd1, 1, 1, 0, 0);
    add_idle(3'd1, 1, 1, 0, 0);
    add_vec(0, 1, 0, 0, 3'd5, 3'd6, 8'd0, 3'd1, 1, 1, 0, 0);
    add_vec(0, 0, 1, 0, 0, 0, 0, 3'd1, 0, 0, 0, 0);
    // Stop on the one-shot end-of-range cycle suppresses done.
    add_vec(0, 1, 0, 0, 3'd5, 3'd5, 8'd0, 3'd5, 1, 1, 0, 0);
    add_vec(0, 0, 1, 0, 0, 0, 0, 3'd5, 0, 0, 0, 0);
    // Continuous single index wraps every cycle; stop on wrap suppresses it.
    add_vec(0, 1, 0, 1, 3'd2, 3'd2, 8'd0, 3'd2, 1, 1, 0, 0);
    add_idle(3'd2, 1, 1, 0, 1);
    add_vec(0, 0, 1, 0, 0, 0, 0, 3'd2, 0, 0, 0, 0);
    // start+stop in IDLE, then reset mid-scan.
    add_vec(0, 1, 1, 0, 3'd3, 3'd4, 8'd0, 3'd2, 0, 0, 0, 0);
    add_idle(3'd2, 0, 0, 0, 0);
    add_vec(0, 1, 0, 1, 3'd3, 3'd3, 8'd5, 3'd3, 1, 1, 0, 0);
    add_idle(3'd3, 1, 1, 0, 0);
    add_vec(1, 1, 0, 1, 3'd6, 3'd7, 8'd0, 3'd0, 0, 0, 0, 0);
    add_vec(0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0);
`else
    // One-shot 0..2, dwell 0, with GAP cycles.
    add_vec(0, 1, 0, 0, 3'd0, 3'd2, 8'd0, 3'd0, 1, 1, 0, 0);
    add_idle(3'd1, 0, 1, 0, 0);
    add_idle(3'd1, 1, 1, 0, 0);
    add_idle(3'd2, 0, 1, 0, 0);
    add_idle(3'd2, 1, 1, 0, 0);
    add_idle(3'd2, 0, 0, 1, 0);
    add_idle(3'd2, 0, 0, 0, 0);
    // Continuous 0..1: wrap pulses in the GAP before index 0.
    add_vec(0, 1, 0, 1, 3'd0, 3'd1, 8'd0, 3'd0, 1, 1, 0, 0);
    add_idle(3'd1, 0, 1, 0, 0);
    add_idle(3'd1, 1, 1, 0, 0);
    add_idle(3'd0, 0, 1, 0, 1);
    add_idle(3'd0, 1, 1, 0, 0);
    add_vec(0, 0, 1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0);
    // Stop during GAP.
    add_vec(0, 1, 0, 0, 3'd3, 3'd4, 8'd0, 3'd3, 1, 1, 0, 0);
    add_idle(3'd4, 0, 1, 0, 0);
    add_vec(0, 0, 1, 0, 0, 0, 0, 3'd4, 0, 0, 0, 0);
    // Reset mid-scan.
    add_vec(0, 1, 0, 1, 3'd5, 3'd6, 8'd2, 3'd5, 1, 1, 0, 0);
    add_vec(1, 1, 0, 1, 3'd6, 3'd7, 8'd0, 3'd0, 0, 0, 0, 0);
    add_vec(0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0);
`endif

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      act = {a, enable, busy, done, wrap};
      exp = {vecs[i].ea, vecs[i].een, vecs[i].ebusy, vecs[i].edone, vecs[i].ewrap};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL vec %0d: a/en/busy/done/wrap got %0d/%b/%b/%b/%b want %0d/%b/%b/%b/%b",
                 i, a, enable, busy, done, wrap,
                 vecs[i].ea, vecs[i].een, vecs[i].ebusy, vecs[i].edone, vecs[i].ewrap);
      end else begin
        $display("vec %0d: a=%0d en=%b busy=%b done=%b wrap=%b ok",
                 i, a, enable, busy, done, wrap);
      end
    end

    // Long dwell across the 7->0 index wrap: two indices x 256 cycles each.
    rst = 1'b0; stop = 1'b0; start = 1'b1; mode_cont = 1'b0;
    first_idx = 3'd7; last_idx = 3'd0; dwell = 8'd255;
    @(posedge clk);
    #1;
    start = 1'b0;
    en_cycles = 0;
    seen_done = 1'b0;
    for (cyc = 0; cyc < 2000; cyc++) begin
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      if (enable) en_cycles++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (!seen_done) begin
      errors++;
      $display("FAIL long_dwell_timeout: no done after %0d cycles, required within 2000", cyc);
    end else begin
      $display("long_dwell: done after %0d cycles", cyc);
    end
    checks++;
    if (en_cycles != 512) begin
      errors++;
      $display("FAIL long_dwell_enable: enable high %0d cycles, required 512", en_cycles);
    end else begin
      $display("long_dwell: enable high %0d cycles ok", en_cycles);
    end
    checks++;
    if (a !== 3'd0 || enable !== 1'b0) begin
      errors++;
      $display("FAIL long_dwell_final: a=%0d en=%b, required a=0 en=0", a, enable);
    end else begin
      $display("long_dwell: final a=%0d ok", a);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
